// File: rtl/lcd_ctrl_pkg.sv
// ============================================================================
// lcd_ctrl_pkg : opcodes, controller states and window address helper
// Rev 1.0
// ============================================================================
`default_nettype none

package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE  = 4'h0,
    CMD_UP     = 4'h1,
    CMD_DOWN   = 4'h2,
    CMD_LEFT   = 4'h3,
    CMD_RIGHT  = 4'h4,
    CMD_MAX    = 4'h5,
    CMD_MIN    = 4'h6,
    CMD_AVG    = 4'h7,
    CMD_CCW    = 4'h8,
    CMD_CW     = 4'h9,
    CMD_MIRX   = 4'hA,
    CMD_MIRY   = 4'hB,
    CMD_RELOAD = 4'hC
  } cmd_e;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  function automatic int win_idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_win_alu.sv
// ============================================================================
// lcd_win_alu : combinational 2x2 window operator (max/min/avg/rotate/mirror)
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [3:0]       op_i,
  input  logic [PIX_W-1:0] tl_i,
  input  logic [PIX_W-1:0] tr_i,
  input  logic [PIX_W-1:0] bl_i,
  input  logic [PIX_W-1:0] br_i,
  output logic [PIX_W-1:0] tl_o,
  output logic [PIX_W-1:0] tr_o,
  output logic [PIX_W-1:0] bl_o,
  output logic [PIX_W-1:0] br_o
);

  logic [PIX_W-1:0] w_max_t, w_max_b, w_max;
  logic [PIX_W-1:0] w_min_t, w_min_b, w_min;
  logic [PIX_W+1:0] w_sum;
  logic [PIX_W-1:0] w_avg;

  assign w_max_t = (tl_i > tr_i) ? tl_i : tr_i;
  assign w_max_b = (bl_i > br_i) ? bl_i : br_i;
  assign w_max   = (w_max_t > w_max_b) ? w_max_t : w_max_b;
  assign w_min_t = (tl_i < tr_i) ? tl_i : tr_i;
  assign w_min_b = (bl_i < br_i) ? bl_i : br_i;
  assign w_min   = (w_min_t < w_min_b) ? w_min_t : w_min_b;

  // Two guard bits make the four-pixel sum exact before the floor divide.
  assign w_sum = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
  assign w_avg = w_sum[PIX_W+1:2];

  always_comb begin
    tl_o = tl_i;
    tr_o = tr_i;
    bl_o = bl_i;
    br_o = br_i;
    case (op_i)
      CMD_MAX: begin
        tl_o = w_max; tr_o = w_max; bl_o = w_max; br_o = w_max;
      end
      CMD_MIN: begin
        tl_o = w_min; tr_o = w_min; bl_o = w_min; br_o = w_min;
      end
      CMD_AVG: begin
        tl_o = w_avg; tr_o = w_avg; bl_o = w_avg; br_o = w_avg;
      end
      CMD_CCW: begin
        tl_o = tr_i; tr_o = br_i; br_o = bl_i; bl_o = tl_i;
      end
      CMD_CW: begin
        tl_o = bl_i; bl_o = br_i; br_o = tr_i; tr_o = tl_i;
      end
      CMD_MIRX: begin
        tl_o = bl_i; bl_o = tl_i; tr_o = br_i; br_o = tr_i;
      end
      CMD_MIRY: begin
        tl_o = tr_i; tr_o = tl_i; bl_o = br_i; br_o = bl_i;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lcd_ctrl_param.sv
// ============================================================================
// lcd_ctrl_param : parametrised image buffer with 2x2 window commands
// Rev 1.0 ; define LCD_CTRL_WRAP_EN for wrapping origin shifts
// ============================================================================
`default_nettype none

module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [PIX_W-1:0]  IROM_Q,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              IRAM_valid,
  output logic [PIX_W-1:0]  IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [XW-1:0] X_MIN = XW'(1);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MIN = YW'(1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  state_e state_q, state_d;

  logic [PIX_W-1:0]  mem_q [NPIX];
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] rom_a_q, rom_a_d;
  logic              busy_q, busy_d;
  logic              ram_v_q, ram_v_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [PIX_W-1:0]  ram_d_q, ram_d_d;
  logic              done_q, done_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [XW-1:0]     ox_q, ox_d;
  logic [YW-1:0]     oy_q, oy_d;

  logic              w_accept;
  logic [ADDR_W-1:0] w_tl_a, w_tr_a, w_bl_a, w_br_a;
  logic [PIX_W-1:0]  w_tl_n, w_tr_n, w_bl_n, w_br_n;

  assign w_accept = (state_q == ST_READY) && cmd_valid && !busy_q;

  assign w_tl_a = ADDR_W'(win_idx(int'(ox_q) - 1, int'(oy_q) - 1, IMG_W));
  assign w_tr_a = ADDR_W'(win_idx(int'(ox_q),     int'(oy_q) - 1, IMG_W));
  assign w_bl_a = ADDR_W'(win_idx(int'(ox_q) - 1, int'(oy_q),     IMG_W));
  assign w_br_a = ADDR_W'(win_idx(int'(ox_q),     int'(oy_q),     IMG_W));

  lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
    .op_i (cmd_q),
    .tl_i (mem_q[w_tl_a]),
    .tr_i (mem_q[w_tr_a]),
    .bl_i (mem_q[w_bl_a]),
    .br_i (mem_q[w_br_a]),
    .tl_o (w_tl_n),
    .tr_o (w_tr_n),
    .bl_o (w_bl_n),
    .br_o (w_br_n)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_LOAD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (rd_q && rom_a_q == LAST_ADDR) state_d = ST_READY;
      ST_READY: begin
        if (w_accept) begin
          if (cmd == CMD_WRITE)       state_d = ST_WRITE;
          else if (cmd == CMD_RELOAD) state_d = ST_LOAD;
          else                        state_d = ST_EXEC;
        end
      end
      ST_EXEC:  state_d = ST_READY;
      ST_WRITE: if (ram_a_q == LAST_ADDR) state_d = ST_READY;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    rd_d    = rd_q;
    rom_a_d = rom_a_q;
    busy_d  = busy_q;
    ram_v_d = 1'b0;
    ram_a_d = ram_a_q;
    ram_d_d = ram_d_q;
    done_d  = 1'b0;
    cmd_d   = cmd_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    case (state_q)
      ST_LOAD: begin
        busy_d = 1'b1;
        // rd_q is low only on the first cycle after reset release
        if (!rd_q) begin
          rd_d = 1'b1;
        end else if (rom_a_q == LAST_ADDR) begin
          rd_d    = 1'b0;
          rom_a_d = '0;
          busy_d  = 1'b0;
        end else begin
          rom_a_d = rom_a_q + 1'b1;
        end
      end
      ST_READY: begin
        if (w_accept) begin
          busy_d = 1'b1;
          cmd_d  = cmd;
          if (cmd == CMD_WRITE) begin
            ram_v_d = 1'b1;
            ram_a_d = '0;
            ram_d_d = mem_q[0];
          end else if (cmd == CMD_RELOAD) begin
            rd_d    = 1'b1;
            rom_a_d = '0;
          end
        end
      end
      ST_EXEC: begin
        busy_d = 1'b0;
        case (cmd_q)
`ifdef LCD_CTRL_WRAP_EN
          CMD_UP:    oy_d = (oy_q == Y_MIN) ? Y_MAX : oy_q - 1'b1;
          CMD_DOWN:  oy_d = (oy_q == Y_MAX) ? Y_MIN : oy_q + 1'b1;
          CMD_LEFT:  ox_d = (ox_q == X_MIN) ? X_MAX : ox_q - 1'b1;
          CMD_RIGHT: ox_d = (ox_q == X_MAX) ? X_MIN : ox_q + 1'b1;
`else
          CMD_UP:    if (oy_q != Y_MIN) oy_d = oy_q - 1'b1;
          CMD_DOWN:  if (oy_q != Y_MAX) oy_d = oy_q + 1'b1;
          CMD_LEFT:  if (ox_q != X_MIN) ox_d = ox_q - 1'b1;
          CMD_RIGHT: if (ox_q != X_MAX) ox_d = ox_q + 1'b1;
`endif
          default: ;
        endcase
      end
      ST_WRITE: begin
        if (ram_a_q == LAST_ADDR) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          ram_v_d = 1'b1;
          ram_a_d = ram_a_q + 1'b1;
          ram_d_d = mem_q[ram_a_q + 1'b1];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= 1'b0;
      rom_a_q <= '0;
      busy_q  <= 1'b1;
      ram_v_q <= 1'b0;
      ram_a_q <= '0;
      ram_d_q <= '0;
      done_q  <= 1'b0;
      cmd_q   <= '0;
      ox_q    <= XW'(IMG_W / 2);
      oy_q    <= YW'(IMG_H / 2);
    end else begin
      rd_q    <= rd_d;
      rom_a_q <= rom_a_d;
      busy_q  <= busy_d;
      ram_v_q <= ram_v_d;
      ram_a_q <= ram_a_d;
      ram_d_q <= ram_d_d;
      done_q  <= done_d;
      cmd_q   <= cmd_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  // Non-window opcodes leave the ALU in pass-through, so EXEC always writes back.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && rd_q) begin
      mem_q[rom_a_q] <= IROM_Q;
    end
    if (state_q == ST_EXEC) begin
      mem_q[w_tl_a] <= w_tl_n;
      mem_q[w_tr_a] <= w_tr_n;
      mem_q[w_bl_a] <= w_bl_n;
      mem_q[w_br_a] <= w_br_n;
    end
  end

  assign IROM_rd    = rd_q;
  assign IROM_A     = rom_a_q;
  assign IRAM_valid = ram_v_q;
  assign IRAM_D     = ram_d_q;
  assign IRAM_A     = ram_a_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire
